register_file: RTL and testbench

- Architectural register file and status register: the receiving end of the stage-2 writeback interface.
- Holds 16 x 32-bit general registers and the carry/zero/neg/over flags.
- Applies full-word and 16-bit immediate writes, and serves three read ports to the decode/ALU stage with write-through bypass.
- Keeps a per-register pending-write scoreboard so the issue stage can stall on read-after-write hazards.

---
 rtl/register_file_pkg.sv | 33 +++
 rtl/register_file_scoreboard.sv | 55 +++++
 rtl/register_file.sv | 111 +++++++++++
 tb/tb_register_file.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared definitions for the architectural register file: immediate merge modes,
// status flag bit positions, and the immediate merge helper used by write and bypass paths.
package register_file_pkg;

  typedef enum logic [1:0] {
    IT_UNSIGNED = 2'd0,
    IT_SIGNED   = 2'd1,
    IT_TOP      = 2'd2,
    IT_BOTTOM   = 2'd3
  } imm_type_e;

  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_NEG   = 2;
  localparam int unsigned FLAG_OVER  = 3;
  localparam int unsigned FLAG_COUNT = 4;

  function automatic logic [31:0] merge_immediate(input imm_type_e  kind,
                                                  input logic [15:0] imm,
                                                  input logic [31:0] old);
    logic [31:0] result;
    result = '0;
    case (kind)
      IT_UNSIGNED: result = {16'h0000, imm};
      IT_SIGNED:   result = {{16{imm[15]}}, imm};
      IT_TOP:      result = {imm, old[15:0]};
      IT_BOTTOM:   result = {old[31:16], imm};
      default:     result = old;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// Per-register pending-write counters: claims increment, writebacks retire,
// with saturation/underflow and double-strobe detection feeding a sticky error.
module register_scoreboard
  import register_file_pkg::*;
#(
  parameter int unsigned REG_COUNT  = 16,
  parameter int unsigned PEND_WIDTH = 2,
  localparam int unsigned INDEX_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   claim,
  input  logic [INDEX_WIDTH-1:0] claim_index,
  input  logic                   retire,
  input  logic [INDEX_WIDTH-1:0] retire_index,
  input  logic                   write_conflict,
  output logic [REG_COUNT-1:0]   pending,
  output logic                   protocol_error
);

  logic [REG_COUNT-1:0] claim_hit;
  logic [REG_COUNT-1:0] retire_hit;
  logic [REG_COUNT-1:0] overflow;
  logic [REG_COUNT-1:0] underflow;

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_count
    logic [PEND_WIDTH-1:0] count;

    assign claim_hit[i]  = claim  && (claim_index  == INDEX_WIDTH'(i));
    assign retire_hit[i] = retire && (retire_index == INDEX_WIDTH'(i));
    // A claim and retire of the same register in one cycle cancel, so neither can fault.
    assign overflow[i]   = claim_hit[i] && !retire_hit[i] && (count == '1);
    assign underflow[i]  = retire_hit[i] && !claim_hit[i] && (count == '0);
    assign pending[i]    = (count != '0);

    always_ff @(posedge clock) begin
      if (reset) begin
        count <= '0;
      end else if (claim_hit[i] && !retire_hit[i]) begin
        if (count != '1) count <= count + 1'b1;
      end else if (retire_hit[i] && !claim_hit[i]) begin
        if (count != '0) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if ((|overflow) || (|underflow) || write_conflict) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with status flags, three bypassed read ports,
// and a pending-write scoreboard for read-after-write stall decisions.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned REG_COUNT  = 16,
  parameter int unsigned PEND_WIDTH = 2,
  localparam int unsigned INDEX_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] read_index_a,
  input  logic [INDEX_WIDTH-1:0] read_index_b,
  input  logic [INDEX_WIDTH-1:0] read_index_c,
  output logic [31:0]            read_data_a,
  output logic [31:0]            read_data_b,
  output logic [31:0]            read_data_c,
  output logic                   pending_a,
  output logic                   pending_b,
  output logic                   pending_c,
  input  logic                   claim,
  input  logic [INDEX_WIDTH-1:0] claim_index,
  input  logic                   write,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [31:0]            write_data,
  input  logic                   write_immediate,
  input  logic [15:0]            write_immediate_data,
  input  logic [1:0]             write_immediate_type,
  input  logic                   status_register_write,
  input  logic                   alu_carry_in,
  input  logic                   alu_zero_in,
  input  logic                   alu_neg_in,
  input  logic                   alu_over_in,
  output logic                   alu_carry,
  output logic                   alu_zero,
  output logic                   alu_neg,
  output logic                   alu_over,
  output logic                   protocol_error
);

  logic [31:0]           regs [REG_COUNT];
  logic [FLAG_COUNT-1:0] flags;
  logic [REG_COUNT-1:0]  pending;
  logic                  write_active;
  logic [31:0]           write_value;

  assign write_active = write || write_immediate;

  // Full-word write takes priority when both strobes collide.
  always_comb begin
    write_value = write_data;
    if (!write) begin
      write_value = merge_immediate(imm_type_e'(write_immediate_type),
                                    write_immediate_data, regs[write_index]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (write_active) begin
      regs[write_index] <= write_value;
    end
  end

  always_comb begin
    read_data_a = regs[read_index_a];
    read_data_b = regs[read_index_b];
    read_data_c = regs[read_index_c];
    if (write_active && (read_index_a == write_index)) read_data_a = write_value;
    if (write_active && (read_index_b == write_index)) read_data_b = write_value;
    if (write_active && (read_index_c == write_index)) read_data_c = write_value;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flags <= '0;
    end else if (status_register_write) begin
      flags[FLAG_CARRY] <= alu_carry_in;
      flags[FLAG_ZERO]  <= alu_zero_in;
      flags[FLAG_NEG]   <= alu_neg_in;
      flags[FLAG_OVER]  <= alu_over_in;
    end
  end

  assign alu_carry = flags[FLAG_CARRY];
  assign alu_zero  = flags[FLAG_ZERO];
  assign alu_neg   = flags[FLAG_NEG];
  assign alu_over  = flags[FLAG_OVER];

  register_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .PEND_WIDTH(PEND_WIDTH)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .claim         (claim),
    .claim_index   (claim_index),
    .retire        (write_active),
    .retire_index  (write_index),
    .write_conflict(write && write_immediate),
    .pending       (pending),
    .protocol_error(protocol_error)
  );

  // Pending uses the pre-edge count; a same-cycle retire still reports a stall.
  assign pending_a = pending[read_index_a];
  assign pending_b = pending[read_index_b];
  assign pending_c = pending[read_index_c];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an array/integer reference model of the register file rules.
module tb_register_file;

  logic        clock, reset;
  logic [3:0]  read_index_a, read_index_b, read_index_c;
  logic [31:0] read_data_a, read_data_b, read_data_c;
  logic        pending_a, pending_b, pending_c;
  logic        claim;
  logic [3:0]  claim_index;
  logic        write;
  logic [3:0]  write_index;
  logic [31:0] write_data;
  logic        write_immediate;
  logic [15:0] write_immediate_data;
  logic [1:0]  write_immediate_type;
  logic        status_register_write;
  logic        alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in;
  logic        alu_carry, alu_zero, alu_neg, alu_over;
  logic        protocol_error;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_regs [16];
  int          m_count [16];
  logic        m_err, m_c, m_z, m_n, m_v;

  register_file #(.REG_COUNT(16), .PEND_WIDTH(2)) dut (
    .clock(clock), .reset(reset),
    .read_index_a(read_index_a), .read_index_b(read_index_b), .read_index_c(read_index_c),
    .read_data_a(read_data_a), .read_data_b(read_data_b), .read_data_c(read_data_c),
    .pending_a(pending_a), .pending_b(pending_b), .pending_c(pending_c),
    .claim(claim), .claim_index(claim_index),
    .write(write), .write_index(write_index), .write_data(write_data),
    .write_immediate(write_immediate), .write_immediate_data(write_immediate_data),
    .write_immediate_type(write_immediate_type),
    .status_register_write(status_register_write),
    .alu_carry_in(alu_carry_in), .alu_zero_in(alu_zero_in),
    .alu_neg_in(alu_neg_in), .alu_over_in(alu_over_in),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_over(alu_over),
    .protocol_error(protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Immediate merge expressed arithmetically on 32-bit values.
  function automatic logic [31:0] m_merge(input int kind, input logic [31:0] imm, input logic [31:0] old);
    case (kind)
      0:       return imm;
      1:       return (imm >= 32768) ? imm + 32'hFFFF0000 : imm;
      2:       return imm * 65536 + (old % 65536);
      default: return (old / 65536) * 65536 + imm;
    endcase
  endfunction

  function automatic logic [31:0] m_write_value();
    if (write) return write_data;
    return m_merge(int'(write_immediate_type), {16'h0000, write_immediate_data}, m_regs[write_index]);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if ((write || write_immediate) && idx == write_index) return m_write_value();
    return m_regs[idx];
  endfunction

  task automatic idle();
    reset = 0; claim = 0; claim_index = 0; write = 0; write_index = 0; write_data = 0;
    write_immediate = 0; write_immediate_data = 0; write_immediate_type = 0;
    status_register_write = 0; alu_carry_in = 0; alu_zero_in = 0; alu_neg_in = 0; alu_over_in = 0;
  endtask

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic step();
    logic        wa;
    logic [31:0] wv;
    @(posedge clock);
    #1;
    wa = write || write_immediate;
    wv = m_write_value();
    if (reset) begin
      for (int i = 0; i < 16; i++) begin m_regs[i] = 0; m_count[i] = 0; end
      m_err = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
    end else begin
      if (!(claim && wa && claim_index == write_index)) begin
        if (claim) begin
          if (m_count[claim_index] == 3) m_err = 1; else m_count[claim_index]++;
        end
        if (wa) begin
          if (m_count[write_index] == 0) m_err = 1; else m_count[write_index]--;
        end
      end
      if (write && write_immediate) m_err = 1;
      if (wa) m_regs[write_index] = wv;
      if (status_register_write) begin
        m_c = alu_carry_in; m_z = alu_zero_in; m_n = alu_neg_in; m_v = alu_over_in;
      end
    end
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      read_index_a = 4'(i); #1;
      tests++; if (read_data_a !== 32'h0) begin fails++; $display("FAIL reset_read r%0d: got %h expected %h", i, read_data_a, 32'h0); end
      tests++; if (pending_a !== 1'b0) begin fails++; $display("FAIL reset_pending r%0d: got %b expected 0", i, pending_a); end
    end
    tests++; if ({alu_carry, alu_zero, alu_neg, alu_over} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {alu_carry, alu_zero, alu_neg, alu_over}); end
    tests++; if (protocol_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", protocol_error); end
  endtask

  task automatic test_immediate();
    do_reset();
    write = 1; write_index = 5; write_data = 32'h12345678; step(); idle();
    write_immediate = 1; write_index = 5; write_immediate_type = 2; write_immediate_data = 16'hABCD; step(); idle();
    read_index_a = 5; #1;
    tests++; if (read_data_a !== 32'hABCD5678) begin fails++; $display("FAIL imm_top: got %h expected %h", read_data_a, 32'hABCD5678); end
    write_immediate = 1; write_index = 5; write_immediate_type = 3; write_immediate_data = 16'h0001; step(); idle();
    read_index_a = 5; #1;
    tests++; if (read_data_a !== 32'hABCD0001) begin fails++; $display("FAIL imm_bottom: got %h expected %h", read_data_a, 32'hABCD0001); end
    write_immediate = 1; write_index = 6; write_immediate_type = 1; write_immediate_data = 16'h8000; step(); idle();
    write_immediate = 1; write_index = 7; write_immediate_type = 0; write_immediate_data = 16'h8000; step(); idle();
    read_index_a = 6; read_index_b = 7; #1;
    tests++; if (read_data_a !== 32'hFFFF8000) begin fails++; $display("FAIL imm_signed: got %h expected %h", read_data_a, 32'hFFFF8000); end
    tests++; if (read_data_b !== 32'h00008000) begin fails++; $display("FAIL imm_unsigned: got %h expected %h", read_data_b, 32'h00008000); end
  endtask

  task automatic test_bypass();
    do_reset();
    read_index_b = 3; write = 1; write_index = 3; write_data = 32'hDEADBEEF; #1;
    tests++; if (read_data_b !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_word: got %h expected %h", read_data_b, 32'hDEADBEEF); end
    step(); idle();
    read_index_c = 3; write_immediate = 1; write_index = 3; write_immediate_type = 2; write_immediate_data = 16'h1111; #1;
    tests++; if (read_data_c !== 32'h1111BEEF) begin fails++; $display("FAIL bypass_imm_top: got %h expected %h", read_data_c, 32'h1111BEEF); end
    step(); idle();
    read_index_c = 3; #1;
    tests++; if (read_data_c !== 32'h1111BEEF) begin fails++; $display("FAIL bypass_committed: got %h expected %h", read_data_c, 32'h1111BEEF); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    claim = 1; claim_index = 9; step(); step(); idle();
    read_index_a = 9; #1;
    tests++; if (pending_a !== 1'b1) begin fails++; $display("FAIL sb_two_claims: got %b expected 1", pending_a); end
    write = 1; write_index = 9; write_data = 32'h1; #1;
    tests++; if (pending_a !== 1'b1) begin fails++; $display("FAIL sb_same_cycle_release: got %b expected 1", pending_a); end
    step(); idle(); read_index_a = 9; #1;
    tests++; if (pending_a !== 1'b1) begin fails++; $display("FAIL sb_one_release: got %b expected 1", pending_a); end
    write = 1; write_index = 9; write_data = 32'h2; step(); idle(); read_index_a = 9; #1;
    tests++; if (pending_a !== 1'b0) begin fails++; $display("FAIL sb_two_releases: got %b expected 0", pending_a); end
    claim = 1; claim_index = 4; step(); idle();
    claim = 1; claim_index = 4; write = 1; write_index = 4; write_data = 32'h44; step(); idle();
    read_index_b = 4; #1;
    tests++; if (pending_b !== 1'b1) begin fails++; $display("FAIL sb_claim_release_same: got %b expected 1", pending_b); end
    write = 1; write_index = 4; step(); idle(); read_index_b = 4; #1;
    tests++; if (pending_b !== 1'b0) begin fails++; $display("FAIL sb_count_was_one: got %b expected 0", pending_b); end
    tests++; if (protocol_error !== 1'b0) begin fails++; $display("FAIL sb_no_error: got %b expected 0", protocol_error); end
  endtask

  task automatic test_errors();
    do_reset();
    claim = 1; claim_index = 2; step(); step(); step(); idle();
    tests++; if (protocol_error !== 1'b0) begin fails++; $display("FAIL err_three_claims: got %b expected 0", protocol_error); end
    claim = 1; claim_index = 2; step(); idle(); read_index_a = 2; #1;
    tests++; if (protocol_error !== 1'b1) begin fails++; $display("FAIL err_saturate: got %b expected 1", protocol_error); end
    tests++; if (pending_a !== 1'b1) begin fails++; $display("FAIL err_saturate_pending: got %b expected 1", pending_a); end
    write = 1; write_index = 2; step(); step(); idle(); read_index_a = 2; #1;
    tests++; if (pending_a !== 1'b1) begin fails++; $display("FAIL err_count_three: got %b expected 1", pending_a); end
    write = 1; write_index = 2; step(); idle(); read_index_a = 2; #1;
    tests++; if (pending_a !== 1'b0) begin fails++; $display("FAIL err_drained: got %b expected 0", pending_a); end
    do_reset();
    write = 1; write_index = 8; write_data = 32'h8; step(); idle(); read_index_a = 8; #1;
    tests++; if (protocol_error !== 1'b1) begin fails++; $display("FAIL err_underflow: got %b expected 1", protocol_error); end
    tests++; if (pending_a !== 1'b0) begin fails++; $display("FAIL err_underflow_count: got %b expected 0", pending_a); end
    do_reset();
    claim = 1; claim_index = 10; step(); step(); idle();
    write = 1; write_immediate = 1; write_index = 10; write_data = 32'hAAAA5555;
    write_immediate_data = 16'h1234; write_immediate_type = 0; read_index_a = 10; #1;
    tests++; if (read_data_a !== 32'hAAAA5555) begin fails++; $display("FAIL err_both_bypass: got %h expected %h", read_data_a, 32'hAAAA5555); end
    step(); idle(); read_index_a = 10; #1;
    tests++; if (read_data_a !== 32'hAAAA5555) begin fails++; $display("FAIL err_both_data: got %h expected %h", read_data_a, 32'hAAAA5555); end
    tests++; if (protocol_error !== 1'b1) begin fails++; $display("FAIL err_both_strobes: got %b expected 1", protocol_error); end
    do_reset(); #1;
    tests++; if (protocol_error !== 1'b0) begin fails++; $display("FAIL err_cleared_by_reset: got %b expected 0", protocol_error); end
  endtask

  task automatic test_flags();
    do_reset();
    status_register_write = 1; alu_carry_in = 1; alu_zero_in = 0; alu_neg_in = 1; alu_over_in = 1; #1;
    tests++; if ({alu_carry, alu_zero, alu_neg, alu_over} !== 4'b0000) begin fails++; $display("FAIL flags_no_bypass: got %b expected 0000", {alu_carry, alu_zero, alu_neg, alu_over}); end
    step(); idle(); #1;
    tests++; if ({alu_carry, alu_zero, alu_neg, alu_over} !== 4'b1011) begin fails++; $display("FAIL flags_latched: got %b expected 1011", {alu_carry, alu_zero, alu_neg, alu_over}); end
    alu_carry_in = 0; alu_zero_in = 1; alu_neg_in = 0; alu_over_in = 0; step(); step(); #1;
    tests++; if ({alu_carry, alu_zero, alu_neg, alu_over} !== 4'b1011) begin fails++; $display("FAIL flags_hold: got %b expected 1011", {alu_carry, alu_zero, alu_neg, alu_over}); end
    do_reset(); #1;
    tests++; if ({alu_carry, alu_zero, alu_neg, alu_over} !== 4'b0000) begin fails++; $display("FAIL flags_reset: got %b expected 0000", {alu_carry, alu_zero, alu_neg, alu_over}); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int          sel;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle();
      reset = ($urandom_range(0, 63) == 0);
      claim = $urandom_range(0, 1) == 1;
      claim_index = 4'($urandom_range(0, 15));
      write_index = 4'($urandom_range(0, 15));
      write_data = $urandom;
      write_immediate_data = 16'($urandom);
      write_immediate_type = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 31);
      write = (sel < 10) || (sel == 31);
      write_immediate = (sel >= 10 && sel < 20) || (sel == 31);
      status_register_write = $urandom_range(0, 3) == 0;
      {alu_carry_in, alu_zero_in, alu_neg_in, alu_over_in} = 4'($urandom);
      read_index_a = 4'($urandom_range(0, 15));
      read_index_b = (n % 3 == 0) ? write_index : 4'($urandom_range(0, 15));
      read_index_c = 4'($urandom_range(0, 15));
      #1;
      exp = m_read(read_index_a);
      tests++; if (read_data_a !== exp) begin fails++; $display("FAIL rand_read_a[%0d]: got %h expected %h", n, read_data_a, exp); end
      exp = m_read(read_index_b);
      tests++; if (read_data_b !== exp) begin fails++; $display("FAIL rand_read_b[%0d]: got %h expected %h", n, read_data_b, exp); end
      exp = m_read(read_index_c);
      tests++; if (read_data_c !== exp) begin fails++; $display("FAIL rand_read_c[%0d]: got %h expected %h", n, read_data_c, exp); end
      tests++; if ({pending_a, pending_b, pending_c} !== {m_count[read_index_a] != 0, m_count[read_index_b] != 0, m_count[read_index_c] != 0}) begin
        fails++; $display("FAIL rand_pending[%0d]: got %b expected %b", n, {pending_a, pending_b, pending_c},
                          {m_count[read_index_a] != 0, m_count[read_index_b] != 0, m_count[read_index_c] != 0});
      end
      tests++; if ({alu_carry, alu_zero, alu_neg, alu_over} !== {m_c, m_z, m_n, m_v}) begin fails++; $display("FAIL rand_flags[%0d]: got %b expected %b", n, {alu_carry, alu_zero, alu_neg, alu_over}, {m_c, m_z, m_n, m_v}); end
      tests++; if (protocol_error !== m_err) begin fails++; $display("FAIL rand_error[%0d]: got %b expected %b", n, protocol_error, m_err); end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    read_index_a = 0; read_index_b = 0; read_index_c = 0;
    for (int i = 0; i < 16; i++) begin m_regs[i] = 0; m_count[i] = 0; end
    m_err = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
    test_reset();
    test_immediate();
    test_bypass();
    test_scoreboard();
    test_errors();
    test_flags();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
